// File: rtl/edge_detector_multi.sv
// Multi-channel registered edge detector: input synchronisers, rise/fall/event
// pulses, sticky flags, saturating event counters and a combined interrupt.
module edge_detector_multi #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH-1:0]         din,
   input  logic [2*NCH-1:0]       mode,
   input  logic [NCH-1:0]         irq_en,
   input  logic [NCH-1:0]         sticky_clr,
   input  logic [NCH-1:0]         cnt_clr,
   output logic [NCH-1:0]         pos_pulse,
   output logic [NCH-1:0]         neg_pulse,
   output logic [NCH-1:0]         evt_pulse,
   output logic [NCH-1:0]         sticky,
   output logic [NCH*CNT_W-1:0]   evt_cnt,
   output logic                   irq
);

   localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [NCH-1:0]       sync_q [SYNC_STAGES];
   logic [NCH-1:0]       prev_q;
   logic [WARM_W-1:0]    warm_q, warm_d;
   logic [NCH-1:0]       pos_q, pos_d;
   logic [NCH-1:0]       neg_q, neg_d;
   logic [NCH-1:0]       evt_q, evt_d;
   logic [NCH-1:0]       sticky_q, sticky_d;
   logic [NCH*CNT_W-1:0] cnt_q, cnt_d;
   logic                 irq_q, irq_d;

   logic [NCH-1:0]       s_c;
   logic [NCH-1:0]       rise_c;
   logic [NCH-1:0]       fall_c;
   logic                 live_c;

   assign s_c    = sync_q[SYNC_STAGES-1];
   assign rise_c = s_c & ~prev_q;
   assign fall_c = ~s_c & prev_q;
   // Detection is masked until the synchroniser holds post-reset samples only
   assign live_c = (warm_q == '0);

   // Synchroniser chain and previous-state register; prev tracks s in every mode
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
         prev_q <= s_c;
      end
   end

   // Next-state for pulses, sticky flags, counters, irq and warm-up count
   always_comb begin
      logic [CNT_W-1:0] cur;
      pos_d    = '0;
      neg_d    = '0;
      evt_d    = '0;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      irq_d    = 1'b0;
      warm_d   = warm_q;
      cur      = '0;

      if (live_c) begin
         pos_d = rise_c;
         neg_d = fall_c;
         for (int i = 0; i < int'(NCH); i++) begin
            evt_d[i] = (mode[2*i] & rise_c[i]) | (mode[2*i+1] & fall_c[i]);
         end
      end

      // Set wins over clear
      sticky_d = (sticky_q & ~sticky_clr) | evt_d;

      // Clear with a coincident event still records that event
      for (int i = 0; i < int'(NCH); i++) begin
         cur = cnt_q[i*CNT_W +: CNT_W];
         if (cnt_clr[i]) begin
            cur = CNT_W'(evt_d[i]);
         end else if (evt_d[i] && (cur != CNT_MAX)) begin
            cur = cur + CNT_W'(1);
         end
         cnt_d[i*CNT_W +: CNT_W] = cur;
      end

      irq_d = |(sticky_q & irq_en);

      if (warm_q != '0) begin
         warm_d = warm_q - WARM_W'(1);
      end
   end

   // Output and control registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q    <= '0;
         neg_q    <= '0;
         evt_q    <= '0;
         sticky_q <= '0;
         cnt_q    <= '0;
         irq_q    <= 1'b0;
         warm_q   <= WARM_INIT;
      end else begin
         pos_q    <= pos_d;
         neg_q    <= neg_d;
         evt_q    <= evt_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         irq_q    <= irq_d;
         warm_q   <= warm_d;
      end
   end

   assign pos_pulse = pos_q;
   assign neg_pulse = neg_q;
   assign evt_pulse = evt_q;
   assign sticky    = sticky_q;
   assign evt_cnt   = cnt_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: directed steps plus random traffic, every
// cycle compared against a sample-history reference model.
module tb_edge_detector_multi;

   localparam int unsigned NCH   = 4;
   localparam int unsigned SS    = 2;
   localparam int unsigned CNT_W = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH-1:0]       din;
   logic [2*NCH-1:0]     mode;
   logic [NCH-1:0]       irq_en;
   logic [NCH-1:0]       sticky_clr;
   logic [NCH-1:0]       cnt_clr;
   logic [NCH-1:0]       pos_pulse;
   logic [NCH-1:0]       neg_pulse;
   logic [NCH-1:0]       evt_pulse;
   logic [NCH-1:0]       sticky;
   logic [NCH*CNT_W-1:0] evt_cnt;
   logic                 irq;

   int tests = 0;
   int fails = 0;

   // Reference model state: din as sampled at recent edges (index 0 newest)
   logic [NCH-1:0]       dh [SS+2];
   int                   since_rst = 0;
   logic [NCH-1:0]       m_pos = '0, m_neg = '0, m_evt = '0, m_sticky = '0;
   logic [NCH*CNT_W-1:0] m_cnt = '0;
   logic                 m_irq = 1'b0;

   edge_detector_multi #(.NCH(NCH), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .irq_en(irq_en),
      .sticky_clr(sticky_clr), .cnt_clr(cnt_clr), .pos_pulse(pos_pulse),
      .neg_pulse(neg_pulse), .evt_pulse(evt_pulse), .sticky(sticky),
      .evt_cnt(evt_cnt), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, update the model from the rules, then compare all outputs
   task automatic tick();
      logic [NCH-1:0]   rise, fall, evt;
      logic [CNT_W-1:0] c;
      @(posedge clk);
      if (!rst_n) begin
         for (int j = 0; j < int'(SS) + 2; j++) dh[j] = '0;
         since_rst = 0;
         m_pos = '0; m_neg = '0; m_evt = '0; m_sticky = '0; m_cnt = '0; m_irq = 1'b0;
      end else begin
         for (int j = int'(SS) + 1; j > 0; j--) dh[j] = dh[j-1];
         dh[0] = din;
         since_rst++;
         // An edge is din(k-SS) differing from din(k-SS-1); masked during warm-up
         if (since_rst > int'(SS) + 1) begin
            rise = dh[SS] & ~dh[SS+1];
            fall = ~dh[SS] & dh[SS+1];
         end else begin
            rise = '0;
            fall = '0;
         end
         for (int i = 0; i < int'(NCH); i++)
            evt[i] = (mode[2*i] && rise[i]) || (mode[2*i+1] && fall[i]);
         m_irq    = |(m_sticky & irq_en);
         m_sticky = (m_sticky & ~sticky_clr) | evt;
         for (int i = 0; i < int'(NCH); i++) begin
            c = m_cnt[i*CNT_W +: CNT_W];
            if (cnt_clr[i])                   c = evt[i] ? CNT_W'(1) : CNT_W'(0);
            else if (evt[i] && c != CNT_W'(7)) c = c + CNT_W'(1);
            m_cnt[i*CNT_W +: CNT_W] = c;
         end
         m_pos = rise;
         m_neg = fall;
         m_evt = evt;
      end
      #1;
      chk("pos_pulse", 32'(pos_pulse), 32'(m_pos));
      chk("neg_pulse", 32'(neg_pulse), 32'(m_neg));
      chk("evt_pulse", 32'(evt_pulse), 32'(m_evt));
      chk("sticky",    32'(sticky),    32'(m_sticky));
      chk("evt_cnt",   32'(evt_cnt),   32'(m_cnt));
      chk("irq",       32'(irq),       32'(m_irq));
   endtask

   initial begin
      for (int j = 0; j < int'(SS) + 2; j++) dh[j] = '0;

      // T1: reset with all inputs high, release; nothing may be reported
      rst_n = 1'b0; din = 4'hF; mode = 8'hFF; irq_en = 4'hF;
      sticky_clr = '0; cnt_clr = '0;
      tick(); tick();
      chk("t1_reset_cnt", 32'(evt_cnt), 32'd0);
      rst_n = 1'b1;
      repeat (8) tick();
      chk("t1_cnt",    32'(evt_cnt), 32'd0);
      chk("t1_sticky", 32'(sticky),  32'd0);
      chk("t1_irq",    32'(irq),     32'd0);

      // T2: rise then fall on all channels under mixed modes
      din = 4'h0; repeat (6) tick();
      mode = 8'b11_10_01_00; cnt_clr = 4'hF; sticky_clr = 4'hF; tick();
      cnt_clr = '0; sticky_clr = '0; irq_en = '0; repeat (3) tick();
      din = 4'hF; tick(); tick();
      chk("t2_pos_early", 32'(pos_pulse), 32'd0);
      tick();
      chk("t2_pos",       32'(pos_pulse), 32'hF);
      chk("t2_evt_rise",  32'(evt_pulse), 32'b1010);
      tick();
      chk("t2_pos_width", 32'(pos_pulse), 32'd0);
      repeat (6) tick();
      din = 4'h0; tick(); tick(); tick();
      chk("t2_neg",       32'(neg_pulse), 32'hF);
      chk("t2_evt_fall",  32'(evt_pulse), 32'b1100);
      tick();
      chk("t2_neg_width", 32'(neg_pulse), 32'd0);
      repeat (6) tick();
      chk("t2_cnt", 32'(evt_cnt), 32'({3'd2, 3'd1, 3'd1, 3'd0}));

      // T3: counter saturation and clear behaviour on ch0
      mode = 8'b00_00_00_01; cnt_clr = 4'hF; tick(); cnt_clr = '0;
      for (int k = 1; k <= 9; k++) begin
         din[0] = 1'b1; repeat (3) tick();
         din[0] = 1'b0; repeat (3) tick();
         chk("t3_cnt", 32'(evt_cnt[2:0]), (k > 7) ? 32'd7 : 32'(k));
      end
      cnt_clr[0] = 1'b1; tick(); cnt_clr[0] = 1'b0;
      chk("t3_clr", 32'(evt_cnt[2:0]), 32'd0);
      din[0] = 1'b1; tick(); tick();
      cnt_clr[0] = 1'b1; tick(); cnt_clr[0] = 1'b0;
      chk("t3_clr_evt", 32'(evt_cnt[2:0]), 32'd1);

      // T4: sticky flag and interrupt on ch2
      mode = 8'b00_01_00_00; irq_en = 4'b0100; din = 4'h0;
      sticky_clr = 4'hF; tick(); sticky_clr = '0;
      repeat (4) tick();
      din[2] = 1'b1; repeat (3) tick();
      chk("t4_sticky_set", 32'(sticky[2]), 32'd1);
      tick();
      chk("t4_irq_set", 32'(irq), 32'd1);
      din[2] = 1'b0; repeat (4) tick();
      din[2] = 1'b1; tick(); tick();
      sticky_clr = 4'b0100; tick(); sticky_clr = '0;
      chk("t4_set_wins", 32'(sticky[2]), 32'd1);
      repeat (3) tick();
      sticky_clr = 4'b0100; tick(); sticky_clr = '0;
      chk("t4_sticky_clr", 32'(sticky[2]), 32'd0);
      chk("t4_irq_lag",    32'(irq),       32'd1);
      tick();
      chk("t4_irq_clr",    32'(irq),       32'd0);

      // T5: mode switch on a steady high input, then a mid-activity reset
      mode = 8'b00_00_00_01; din = 4'h1; repeat (5) tick();
      mode = 8'b00_00_00_10;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t5_mode_sw", 32'(evt_pulse), 32'd0);
      end
      mode = 8'hFF; irq_en = 4'hF; din = 4'hA; tick(); din = 4'h5; tick();
      din = 4'h0; rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("t5_rst_cnt",    32'(evt_cnt), 32'd0);
      chk("t5_rst_sticky", 32'(sticky),  32'd0);
      chk("t5_rst_irq",    32'(irq),     32'd0);
      repeat (6) tick();
      din = 4'hF; repeat (6) tick();
      chk("t5_resume", 32'(evt_cnt), 32'({3'd1, 3'd1, 3'd1, 3'd1}));

      // Random traffic: glitches, mode/enable changes, clears, occasional reset
      for (int k = 0; k < 600; k++) begin
         din        = din ^ (4'($urandom) & 4'($urandom));
         if ($urandom_range(0, 19) == 0) mode   = 8'($urandom);
         if ($urandom_range(0, 9)  == 0) irq_en = 4'($urandom);
         sticky_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
         cnt_clr    = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
         rst_n      = ($urandom_range(0, 99) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
